id_control_pipe: RTL and testbench

- Second-generation decode control for the 5-stage MIPS32 pipeline.
- Decodes the ID opcode into the control bundle and carries it through registered ID/EX, EX/MEM and MEM/WB control stages.
- Performs load-use hazard detection internally, with a parametrised stall length, and inserts bubbles.
- Adds BNE and ADDI decode, an illegal-opcode flag and a flush input for branch/jump redirects.

---
 rtl/id_control_pipe.sv | 188 ++++++++++++++++++
 tb/tb_id_control_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_control_pipe.sv
// -----------------------------------------------------------------------------
// id_control_pipe
//
// Decode control for a 5-stage MIPS32 pipeline. The opcode of the instruction
// in ID is decoded into the control bundle, which then travels through the
// registered ID/EX, EX/MEM and MEM/WB control stages. Load-use hazards are
// detected here. Each hazard holds ID for LOAD_STALL_CYCLES cycles and sends
// one bubble into EX per stalled cycle. A flush squashes the instruction in ID.
//
// Parameters
//   REG_W             register-address width of rs/rt
//   LOAD_STALL_CYCLES bubbles per load-use hazard (1..3)
//   HAZARD_EN         1 = internal load-use detection, 0 = never stall
//
// Ports
//   clk        pipeline clock
//   reset      synchronous, active-high reset
//   opcode_id  Instruction[31:26] of the instruction in ID
//   rs_id      rs of the instruction in ID
//   rt_id      rt of the instruction in ID
//   flush_id   squash the ID instruction (taken branch/jump)
//   ex_ctrl    ID/EX {RegWrite,MemtoReg,Branch,Jump,MemRead,MemWrite,RegDst,ALUOp[1:0]}
//   ex_alusrc  ID/EX ALUSrc
//   ex_bne     ID/EX branch-on-not-equal qualifier
//   ex_rt      rt carried with the ID/EX bundle
//   mem_ctrl   EX/MEM {RegWrite,MemtoReg,Branch,MemRead,MemWrite}
//   wb_ctrl    MEM/WB {RegWrite,MemtoReg}
//   stall_id   combinational; hold PC and IF/ID this cycle
//   illegal_ex the instruction now in EX had an undefined opcode
// -----------------------------------------------------------------------------
module id_control_pipe #(
  parameter int REG_W             = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter bit HAZARD_EN         = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode_id,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             flush_id,
  output logic [8:0]       ex_ctrl,
  output logic             ex_alusrc,
  output logic             ex_bne,
  output logic [REG_W-1:0] ex_rt,
  output logic [4:0]       mem_ctrl,
  output logic [1:0]       wb_ctrl,
  output logic             stall_id,
  output logic             illegal_ex
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_NOP   = 6'b100000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  // Bit positions inside the 9-bit ID/EX control bundle.
  localparam int C_REGWRITE = 8;
  localparam int C_MEMTOREG = 7;
  localparam int C_BRANCH   = 6;
  localparam int C_MEMREAD  = 4;
  localparam int C_MEMWRITE = 3;

  // First value of the stall counter once a hazard is seen. The hazard
  // cycle itself is the first stall cycle.
  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

  typedef struct packed {
    logic [8:0] ctrl;
    logic       alusrc;
    logic       bne;
    logic       illegal;
  } dec_t;

  dec_t             dec;
  logic             uses_rt;
  logic             hz;

  dec_t             idex_d,  idex_q;
  logic [REG_W-1:0] ex_rt_d, ex_rt_q;
  logic [1:0]       cnt_d,   cnt_q;
  logic [4:0]       mem_ctrl_q;
  logic [1:0]       wb_ctrl_q;

  // ---------------------------------------------------------------------------
  // ID decode
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    dec     = '0;
    uses_rt = 1'b0;
    case (opcode_id)
      OP_RTYPE: begin dec.ctrl = 9'b100000110; uses_rt = 1'b1; end
      OP_LW:    begin dec.ctrl = 9'b110010000; dec.alusrc = 1'b1; end
      OP_SW:    begin dec.ctrl = 9'b000001000; dec.alusrc = 1'b1; uses_rt = 1'b1; end
      OP_BEQ:   begin dec.ctrl = 9'b001000001; uses_rt = 1'b1; end
      OP_BNE:   begin dec.ctrl = 9'b001000001; dec.bne = 1'b1; uses_rt = 1'b1; end
      OP_ADDI:  begin dec.ctrl = 9'b100000000; dec.alusrc = 1'b1; end
      OP_J:     dec.ctrl = 9'b000100000;
      OP_NOP:   dec = '0;
      default:  dec.illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard and stall counter
  // ---------------------------------------------------------------------------
  // ADDI and LW write rt, so for them only rs can depend on the load.
  always_comb begin
    hz = 1'b0;
    if (HAZARD_EN) begin
      hz = idex_q.ctrl[C_MEMREAD] && (ex_rt_q != '0) &&
           ((ex_rt_q == rs_id) || (uses_rt && (ex_rt_q == rt_id)));
    end
  end

  // A flush removes the stalled instruction, so there is nothing left to hold.
  always_comb begin
    stall_id = 1'b0;
    if (!reset && !flush_id) begin
      stall_id = (hz && (cnt_q == 2'd0)) || (cnt_q != 2'd0);
    end
  end

  // While cnt_q is nonzero EX holds a bubble, so hz cannot fire again until
  // the current stall has finished.
  always_comb begin
    cnt_d = 2'd0;
    if (flush_id) begin
      cnt_d = 2'd0;
    end else if (cnt_q != 2'd0) begin
      cnt_d = cnt_q - 2'd1;
    end else if (hz) begin
      cnt_d = STALL_INIT;
    end
  end

  // ---------------------------------------------------------------------------
  // ID/EX next state: flush and stall both insert a bubble
  // ---------------------------------------------------------------------------
  always_comb begin
    idex_d  = dec;
    ex_rt_d = rt_id;
    if (flush_id || stall_id) begin
      idex_d  = '0;
      ex_rt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers. EX/MEM and MEM/WB never stall.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every stage
  // samples the value its predecessor held before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q     <= '0;
      ex_rt_q    <= '0;
      cnt_q      <= 2'd0;
      mem_ctrl_q <= '0;
      wb_ctrl_q  <= '0;
    end else begin
      idex_q     <= idex_d;
      ex_rt_q    <= ex_rt_d;
      cnt_q      <= cnt_d;
      mem_ctrl_q <= {idex_q.ctrl[C_REGWRITE], idex_q.ctrl[C_MEMTOREG],
                     idex_q.ctrl[C_BRANCH], idex_q.ctrl[C_MEMREAD],
                     idex_q.ctrl[C_MEMWRITE]};
      wb_ctrl_q  <= mem_ctrl_q[4:3];
    end
  end

  assign ex_ctrl    = idex_q.ctrl;
  assign ex_alusrc  = idex_q.alusrc;
  assign ex_bne     = idex_q.bne;
  assign illegal_ex = idex_q.illegal;
  assign ex_rt      = ex_rt_q;
  assign mem_ctrl   = mem_ctrl_q;
  assign wb_ctrl    = wb_ctrl_q;

endmodule

// File: tb/tb_id_control_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_control_pipe
//
// Three instances share one set of inputs: N=1 with hazard detection,
// N=3 with hazard detection, and N=1 with detection disabled. Each scenario
// task works on one instance, starting from a reset. Every step pushes the
// expected ID/EX contents into a scoreboard queue. The entry is popped and
// compared after the following clock edge. Expected EX/MEM and MEM/WB values
// are derived from the earlier expected ID/EX values.
// -----------------------------------------------------------------------------
module tb_id_control_pipe;

  typedef struct packed {
    logic [8:0] ctrl;
    logic       alusrc;
    logic       bne;
    logic       ill;
    logic [4:0] rt;
  } exp_t;

  localparam logic [5:0] RTYPE = 6'b000000, LW  = 6'b100011, SW  = 6'b101011,
                         BEQ   = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                         J     = 6'b000010, NOP = 6'b100000, BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'b0;
  logic [4:0] rs = 5'd0;
  logic [4:0] rt = 5'd0;
  logic       flush = 1'b0;

  logic [8:0] ex_ctrl  [3];
  logic       ex_alusrc[3];
  logic       ex_bne   [3];
  logic [4:0] ex_rt    [3];
  logic [4:0] mem_ctrl [3];
  logic [1:0] wb_ctrl  [3];
  logic       stall    [3];
  logic       ill      [3];

  int n_cmp = 0;
  int n_bad = 0;
  int cur_sel = 0;

  exp_t       sb[$];
  exp_t       prev_ex  = '0;
  logic [4:0] prev_mem = '0;

  always #5 clk = ~clk;

  id_control_pipe #(.REG_W(5), .LOAD_STALL_CYCLES(1), .HAZARD_EN(1'b1)) u_n1 (
    .clk(clk), .reset(rst), .opcode_id(op), .rs_id(rs), .rt_id(rt), .flush_id(flush),
    .ex_ctrl(ex_ctrl[0]), .ex_alusrc(ex_alusrc[0]), .ex_bne(ex_bne[0]), .ex_rt(ex_rt[0]),
    .mem_ctrl(mem_ctrl[0]), .wb_ctrl(wb_ctrl[0]), .stall_id(stall[0]), .illegal_ex(ill[0]));

  id_control_pipe #(.REG_W(5), .LOAD_STALL_CYCLES(3), .HAZARD_EN(1'b1)) u_n3 (
    .clk(clk), .reset(rst), .opcode_id(op), .rs_id(rs), .rt_id(rt), .flush_id(flush),
    .ex_ctrl(ex_ctrl[1]), .ex_alusrc(ex_alusrc[1]), .ex_bne(ex_bne[1]), .ex_rt(ex_rt[1]),
    .mem_ctrl(mem_ctrl[1]), .wb_ctrl(wb_ctrl[1]), .stall_id(stall[1]), .illegal_ex(ill[1]));

  id_control_pipe #(.REG_W(5), .LOAD_STALL_CYCLES(1), .HAZARD_EN(1'b0)) u_off (
    .clk(clk), .reset(rst), .opcode_id(op), .rs_id(rs), .rt_id(rt), .flush_id(flush),
    .ex_ctrl(ex_ctrl[2]), .ex_alusrc(ex_alusrc[2]), .ex_bne(ex_bne[2]), .ex_rt(ex_rt[2]),
    .mem_ctrl(mem_ctrl[2]), .wb_ctrl(wb_ctrl[2]), .stall_id(stall[2]), .illegal_ex(ill[2]));

  function automatic exp_t mk(input logic [8:0] c, input logic a, input logic b,
                              input logic i, input logic [4:0] r);
    mk = '{ctrl: c, alusrc: a, bne: b, ill: i, rt: r};
  endfunction

  localparam exp_t BUBBLE = '0;

  // One pipeline clock: drive ID inputs at the falling edge and check stall_id.
  // Then queue the expected ID/EX contents, and after the rising edge pop the
  // entry and compare the EX, MEM and WB stages.
  task automatic cyc(input string tag, input int sel, input logic r,
                     input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                     input logic f, input logic es, input exp_t e);
    exp_t       got;
    exp_t       obs;
    logic [4:0] exp_mem;
    logic [1:0] exp_wb;
    @(negedge clk);
    cur_sel = sel;
    rst = r; op = o; rs = s; rt = t; flush = f;
    #1;
    n_cmp++;
    if (stall[sel] !== es) begin
      n_bad++;
      $display("FAIL %s stall_id got %b want %b", tag, stall[sel], es);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    exp_mem = r ? 5'b0 : {prev_ex.ctrl[8], prev_ex.ctrl[7], prev_ex.ctrl[6],
                          prev_ex.ctrl[4], prev_ex.ctrl[3]};
    exp_wb  = r ? 2'b0 : prev_mem[4:3];
    obs = mk(ex_ctrl[sel], ex_alusrc[sel], ex_bne[sel], ill[sel], ex_rt[sel]);
    n_cmp++;
    if (obs !== got) begin
      n_bad++;
      $display("FAIL %s ex {ctrl,alusrc,bne,ill,rt} got %b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d",
               tag, obs.ctrl, obs.alusrc, obs.bne, obs.ill, obs.rt,
               got.ctrl, got.alusrc, got.bne, got.ill, got.rt);
    end
    n_cmp++;
    if (mem_ctrl[sel] !== exp_mem) begin
      n_bad++;
      $display("FAIL %s mem_ctrl got %b want %b", tag, mem_ctrl[sel], exp_mem);
    end
    n_cmp++;
    if (wb_ctrl[sel] !== exp_wb) begin
      n_bad++;
      $display("FAIL %s wb_ctrl got %b want %b", tag, wb_ctrl[sel], exp_wb);
    end
    prev_ex  = got;
    prev_mem = exp_mem;
  endtask

  task automatic do_reset(input int sel);
    cyc("reset0", sel, 1'b1, RTYPE, 5'd1, 5'd2, 1'b0, 1'b0, BUBBLE);
    cyc("reset1", sel, 1'b1, RTYPE, 5'd1, 5'd2, 1'b0, 1'b0, BUBBLE);
  endtask

  task automatic test_reset();
    do_reset(0);
    cyc("rst_rtype", 0, 1'b0, RTYPE, 5'd1, 5'd2, 1'b0, 1'b0, mk(9'b100000110, 0, 0, 0, 5'd2));
    cyc("rst_nop",   0, 1'b0, NOP,   5'd0, 5'd0, 1'b0, 1'b0, mk(9'b0, 0, 0, 0, 5'd0));
  endtask

  task automatic test_decode_stream();
    do_reset(0);
    cyc("dec_lw",   0, 1'b0, LW,   5'd2,  5'd3,  1'b0, 1'b0, mk(9'b110010000, 1, 0, 0, 5'd3));
    cyc("dec_sw",   0, 1'b0, SW,   5'd4,  5'd5,  1'b0, 1'b0, mk(9'b000001000, 1, 0, 0, 5'd5));
    cyc("dec_beq",  0, 1'b0, BEQ,  5'd6,  5'd7,  1'b0, 1'b0, mk(9'b001000001, 0, 0, 0, 5'd7));
    cyc("dec_bne",  0, 1'b0, BNE,  5'd8,  5'd9,  1'b0, 1'b0, mk(9'b001000001, 0, 1, 0, 5'd9));
    cyc("dec_addi", 0, 1'b0, ADDI, 5'd10, 5'd11, 1'b0, 1'b0, mk(9'b100000000, 1, 0, 0, 5'd11));
    cyc("dec_j",    0, 1'b0, J,    5'd12, 5'd13, 1'b0, 1'b0, mk(9'b000100000, 0, 0, 0, 5'd13));
    cyc("dec_nop",  0, 1'b0, NOP,  5'd14, 5'd15, 1'b0, 1'b0, mk(9'b0, 0, 0, 0, 5'd15));
    cyc("drain0",   0, 1'b0, NOP,  5'd0,  5'd0,  1'b0, 1'b0, mk(9'b0, 0, 0, 0, 5'd0));
    cyc("drain1",   0, 1'b0, NOP,  5'd0,  5'd0,  1'b0, 1'b0, mk(9'b0, 0, 0, 0, 5'd0));
  endtask

  task automatic test_load_use();
    do_reset(0);
    cyc("lu1_lw",    0, 1'b0, LW,    5'd1, 5'd5, 1'b0, 1'b0, mk(9'b110010000, 1, 0, 0, 5'd5));
    cyc("lu1_stall", 0, 1'b0, RTYPE, 5'd5, 5'd2, 1'b0, 1'b1, BUBBLE);
    cyc("lu1_issue", 0, 1'b0, RTYPE, 5'd5, 5'd2, 1'b0, 1'b0, mk(9'b100000110, 0, 0, 0, 5'd2));
    cyc("lu1_lw_r0", 0, 1'b0, LW,    5'd1, 5'd0, 1'b0, 1'b0, mk(9'b110010000, 1, 0, 0, 5'd0));
    cyc("lu1_r0",    0, 1'b0, RTYPE, 5'd0, 5'd0, 1'b0, 1'b0, mk(9'b100000110, 0, 0, 0, 5'd0));
    do_reset(1);
    cyc("lu3_lw",    1, 1'b0, LW,    5'd1, 5'd5, 1'b0, 1'b0, mk(9'b110010000, 1, 0, 0, 5'd5));
    for (int i = 0; i < 3; i++)
      cyc($sformatf("lu3_stall%0d", i), 1, 1'b0, RTYPE, 5'd5, 5'd2, 1'b0, 1'b1, BUBBLE);
    cyc("lu3_issue", 1, 1'b0, RTYPE, 5'd5, 5'd2, 1'b0, 1'b0, mk(9'b100000110, 0, 0, 0, 5'd2));
  endtask

  task automatic test_rt_source();
    do_reset(0);
    cyc("rt_lw",       0, 1'b0, LW,   5'd1, 5'd7, 1'b0, 1'b0, mk(9'b110010000, 1, 0, 0, 5'd7));
    cyc("rt_addi",     0, 1'b0, ADDI, 5'd1, 5'd7, 1'b0, 1'b0, mk(9'b100000000, 1, 0, 0, 5'd7));
    cyc("rt_lw2",      0, 1'b0, LW,   5'd1, 5'd7, 1'b0, 1'b0, mk(9'b110010000, 1, 0, 0, 5'd7));
    cyc("rt_sw_stall", 0, 1'b0, SW,   5'd1, 5'd7, 1'b0, 1'b1, BUBBLE);
    cyc("rt_sw_issue", 0, 1'b0, SW,   5'd1, 5'd7, 1'b0, 1'b0, mk(9'b000001000, 1, 0, 0, 5'd7));
  endtask

  task automatic test_flush();
    do_reset(1);
    cyc("fl_lw",     1, 1'b0, LW,    5'd1, 5'd5, 1'b0, 1'b0, mk(9'b110010000, 1, 0, 0, 5'd5));
    cyc("fl_stall0", 1, 1'b0, RTYPE, 5'd5, 5'd2, 1'b0, 1'b1, BUBBLE);
    cyc("fl_flush",  1, 1'b0, RTYPE, 5'd5, 5'd2, 1'b1, 1'b0, BUBBLE);
    cyc("fl_next",   1, 1'b0, ADDI,  5'd1, 5'd2, 1'b0, 1'b0, mk(9'b100000000, 1, 0, 0, 5'd2));
    cyc("fl_plain",  1, 1'b0, RTYPE, 5'd3, 5'd4, 1'b1, 1'b0, BUBBLE);
  endtask

  task automatic test_back_to_back();
    do_reset(0);
    cyc("bb_lw1",    0, 1'b0, LW,    5'd1, 5'd5, 1'b0, 1'b0, mk(9'b110010000, 1, 0, 0, 5'd5));
    cyc("bb_stall1", 0, 1'b0, LW,    5'd5, 5'd6, 1'b0, 1'b1, BUBBLE);
    cyc("bb_lw2",    0, 1'b0, LW,    5'd5, 5'd6, 1'b0, 1'b0, mk(9'b110010000, 1, 0, 0, 5'd6));
    cyc("bb_stall2", 0, 1'b0, RTYPE, 5'd6, 5'd1, 1'b0, 1'b1, BUBBLE);
    cyc("bb_rtype",  0, 1'b0, RTYPE, 5'd6, 5'd1, 1'b0, 1'b0, mk(9'b100000110, 0, 0, 0, 5'd1));
  endtask

  task automatic test_illegal();
    do_reset(0);
    cyc("ill_op",  0, 1'b0, BAD, 5'd1, 5'd3, 1'b0, 1'b0, mk(9'b0, 0, 0, 1, 5'd3));
    cyc("ill_off", 0, 1'b0, NOP, 5'd1, 5'd3, 1'b0, 1'b0, mk(9'b0, 0, 0, 0, 5'd3));
  endtask

  task automatic test_reset_mid_stall();
    do_reset(1);
    cyc("rms_lw",    1, 1'b0, LW,    5'd1, 5'd5, 1'b0, 1'b0, mk(9'b110010000, 1, 0, 0, 5'd5));
    cyc("rms_stall", 1, 1'b0, RTYPE, 5'd5, 5'd2, 1'b0, 1'b1, BUBBLE);
    cyc("rms_reset", 1, 1'b1, RTYPE, 5'd5, 5'd2, 1'b0, 1'b0, BUBBLE);
    cyc("rms_issue", 1, 1'b0, RTYPE, 5'd5, 5'd2, 1'b0, 1'b0, mk(9'b100000110, 0, 0, 0, 5'd2));
  endtask

  task automatic test_hazard_off();
    do_reset(2);
    cyc("off_lw",    2, 1'b0, LW,    5'd1, 5'd5, 1'b0, 1'b0, mk(9'b110010000, 1, 0, 0, 5'd5));
    cyc("off_dep",   2, 1'b0, RTYPE, 5'd5, 5'd2, 1'b0, 1'b0, mk(9'b100000110, 0, 0, 0, 5'd2));
    cyc("off_flush", 2, 1'b0, RTYPE, 5'd5, 5'd2, 1'b1, 1'b0, BUBBLE);
  endtask

  initial begin
    test_reset();
    test_decode_stream();
    test_load_use();
    test_rt_source();
    test_flush();
    test_back_to_back();
    test_illegal();
    test_reset_mid_stall();
    test_hazard_off();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
